load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the byte-addressed data-memory interface (storetype / MemReadEn / MemWriteEn / AddressBus / data in / data out).
- Accepts one load or store request at a time from the execute stage and computes the effective address.
- Drives the memory with registered controls and captures the memory's registered read data one cycle after issue.
- Sign- or zero-extends load data per RISC-V funct3 and returns a response with backpressure. Used by the single-cycle and multi-cycle cores in front of the data memory.

Parameters:
- MEMORY_BITS, 10, address bits decoded by the data memory; memory size = 2**MEMORY_BITS bytes.
- XLEN, 64, datapath width; must match `BIT_WIDTH.

Ports:
- clock  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: LB0 LH1 LW2 LD3 LBU4 LHU5 LWU6; SB0 SH1 SW2 SD3
- req_base  input  XLEN  rs1 value
- req_offset  input  XLEN  sign-extended immediate
- req_wdata  input  XLEN  rs2 value (stores)
- req_rd  input  5  destination tag, returned unchanged
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_data  output  XLEN  extended load data; 0 for stores and faults
- resp_rd  output  5  tag of the request
- resp_fault  output  1  access rejected
- mem_storetype  output  4  `STORE_* code to the memory
- mem_read_en  output  1  MemReadEn
- mem_write_en  output  1  MemWriteEn
- mem_address  output  XLEN  AddressBus
- mem_wdata  output  XLEN  DataMemoryInput
- mem_rdata  input  XLEN  DataMemoryOutput (registered in the memory; zero when read not enabled)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0 except req_ready=1.
  - A request in flight is dropped. Because mem_write_en clears immediately, no write occurs at the next edge.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch request; addr = req_base + req_offset, modulo 2**XLEN.
  - If the request faults -> RESP with resp_fault=1 and no memory access. Otherwise -> ISSUE.
- Fault conditions:
  - addr[XLEN-1:MEMORY_BITS] != 0.
  - addr[MEMORY_BITS-1:0] + size - 1 > 2**MEMORY_BITS - 1, where size = 1/2/4/8 from funct3[1:0].
  - Load with funct3==7.
  - Store with funct3[2]==1.
- Misaligned addresses are legal; the memory is byte-addressed.
- ISSUE (exactly 1 cycle):
  - mem_address=addr.
  - Load: mem_read_en=1.
  - Store: mem_write_en=1, mem_wdata=req_wdata, mem_storetype = `STORE_BYTE/HALFWORD/WORD/DOUBLEWORD.
  - Next state: load -> CAPTURE; store -> RESP.
- CAPTURE (1 cycle):
  - Controls are 0.
  - Sample mem_rdata, which is valid only in this cycle.
  - Extend mem_rdata[8*size-1:0]: signed for funct3<4, zero-extended otherwise.
  - -> RESP.
- RESP:
  - resp_valid=1; resp_data, resp_rd and resp_fault are stable until resp_ready.
  - On resp_ready -> IDLE. The response is held indefinitely while resp_ready=0.
- Latency from accept to resp_valid: load 3 cycles, store 2, fault 1.
- req_ready=0 in every state except IDLE; at most one outstanding request.
- mem_read_en and mem_write_en are never both 1. Both are 0 outside ISSUE.
- mem_address, mem_wdata and mem_storetype hold their last value outside ISSUE.

Decomposition:
- defs.h holds:
  - `STORE_BYTE/HALFWORD/WORD/DOUBLEWORD (existing).
  - New `LOAD_LB..`LOAD_LWU funct3 constants.
  - LSU state encodings.
- One sub-module, load_extend: combinational funct3 + raw 64 bits -> extended 64 bits. It is reused by the pipelined core.

Test Plan:
1. SD base=0x10 off=0 wdata=0x8877665544332211, then LD base=0x8 off=0x8 -> store resp at +2 cycles; memory bytes 0x10..0x17 = 11..88; load resp_data=0x8877665544332211 at +3 cycles, resp_fault=0.
2. SB 0xF0 at addr 0x20, then LB and LBU at 0x20 -> LB resp_data=0xFFFFFFFFFFFFFFF0; LBU resp_data=0x00000000000000F0; neighbouring bytes unchanged.
3. LW at addr 2**MEMORY_BITS-2 -> resp_fault=1 at +1 cycle; mem_read_en never asserted; resp_data=0.
4. Load with resp_ready held 0 for 5 cycles while req_valid stays 1 -> resp_valid and resp_data stable; req_ready=0 throughout; next request accepted in the cycle after the resp_ready handshake.
5. SW issued, rst pulled low during the ISSUE cycle before the edge -> mem_write_en drops immediately; memory unchanged; after release req_ready=1, resp_valid=0.
6. LH at misaligned addr 0x31 with bytes 0x31=0x34, 0x32=0x92 -> resp_data=0xFFFFFFFFFFFF9234.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and helpers for the load/store unit
// and its load-extension sub-block.
package load_store_unit_pkg;

   localparam int unsigned STORE_W  = 4;
   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned RD_W     = 5;

   localparam logic [STORE_W-1:0] STORE_NONE       = 4'd0;
   localparam logic [STORE_W-1:0] STORE_BYTE       = 4'd1;
   localparam logic [STORE_W-1:0] STORE_HALFWORD   = 4'd2;
   localparam logic [STORE_W-1:0] STORE_WORD       = 4'd3;
   localparam logic [STORE_W-1:0] STORE_DOUBLEWORD = 4'd4;

   localparam logic [FUNCT3_W-1:0] LOAD_LB  = 3'd0;
   localparam logic [FUNCT3_W-1:0] LOAD_LH  = 3'd1;
   localparam logic [FUNCT3_W-1:0] LOAD_LW  = 3'd2;
   localparam logic [FUNCT3_W-1:0] LOAD_LD  = 3'd3;
   localparam logic [FUNCT3_W-1:0] LOAD_LBU = 3'd4;
   localparam logic [FUNCT3_W-1:0] LOAD_LHU = 3'd5;
   localparam logic [FUNCT3_W-1:0] LOAD_LWU = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } lsu_state_e;

   // Request fields kept for the whole transaction.
   typedef struct packed {
      logic                is_store;
      logic [FUNCT3_W-1:0] funct3;
      logic [RD_W-1:0]     rd;
   } lsu_tag_t;

   function automatic logic [3:0] size_m1(input logic [1:0] f);
      case (f)
         2'd0:    size_m1 = 4'd0;
         2'd1:    size_m1 = 4'd1;
         2'd2:    size_m1 = 4'd3;
         default: size_m1 = 4'd7;
      endcase
   endfunction

   function automatic logic [STORE_W-1:0] store_code(input logic [1:0] f);
      case (f)
         2'd0:    store_code = STORE_BYTE;
         2'd1:    store_code = STORE_HALFWORD;
         2'd2:    store_code = STORE_WORD;
         default: store_code = STORE_DOUBLEWORD;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational RISC-V load data extension: picks the low 1/2/4/8 bytes
// and sign- or zero-extends them according to funct3.
module load_extend
   import load_store_unit_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [FUNCT3_W-1:0] i_funct3,
   input  logic [XLEN-1:0]     i_raw,
   output logic [XLEN-1:0]     o_data_c
);

   always_comb begin
      o_data_c = '0;
      case (i_funct3)
         LOAD_LB:  o_data_c = XLEN'($signed(i_raw[7:0]));
         LOAD_LH:  o_data_c = XLEN'($signed(i_raw[15:0]));
         LOAD_LW:  o_data_c = XLEN'($signed(i_raw[31:0]));
         LOAD_LD:  o_data_c = i_raw;
         LOAD_LBU: o_data_c = XLEN'(i_raw[7:0]);
         LOAD_LHU: o_data_c = XLEN'(i_raw[15:0]);
         LOAD_LWU: o_data_c = XLEN'(i_raw[31:0]);
         default:  o_data_c = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a byte-addressed data memory
// with registered read data; all outputs are registered.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEMORY_BITS = 10,
   parameter int unsigned XLEN        = 64
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_store,
   input  logic [FUNCT3_W-1:0] req_funct3,
   input  logic [XLEN-1:0]     req_base,
   input  logic [XLEN-1:0]     req_offset,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [RD_W-1:0]     req_rd,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [XLEN-1:0]     resp_data,
   output logic [RD_W-1:0]     resp_rd,
   output logic                resp_fault,
   output logic [STORE_W-1:0]  mem_storetype,
   output logic                mem_read_en,
   output logic                mem_write_en,
   output logic [XLEN-1:0]     mem_address,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int unsigned AW = MEMORY_BITS + 1;

   lsu_state_e r_state, w_state_nxt;
   lsu_tag_t   r_tag, w_tag_nxt;

   logic [XLEN-1:0]    w_addr;
   logic [AW-1:0]      w_end;
   logic               w_fault;
   logic [XLEN-1:0]    w_ext;
   logic               w_req_ready_nxt, w_resp_valid_nxt, w_resp_fault_nxt;
   logic [XLEN-1:0]    w_resp_data_nxt, w_address_nxt, w_wdata_nxt;
   logic [RD_W-1:0]    w_resp_rd_nxt;
   logic [STORE_W-1:0] w_storetype_nxt;
   logic               w_read_en_nxt, w_write_en_nxt;

   // Last byte touched must stay inside the decoded memory window.
   assign w_addr  = req_base + req_offset;
   assign w_end   = {1'b0, w_addr[MEMORY_BITS-1:0]} + AW'(size_m1(req_funct3[1:0]));
   assign w_fault = (|w_addr[XLEN-1:MEMORY_BITS])
                  | (w_end > AW'((1 << MEMORY_BITS) - 1))
                  | (!req_is_store && (req_funct3 == 3'd7))
                  | (req_is_store && req_funct3[2]);

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .i_funct3 (r_tag.funct3),
      .i_raw    (mem_rdata),
      .o_data_c (w_ext)
   );

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_tag         <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_rd       <= '0;
         resp_fault    <= 1'b0;
         mem_storetype <= STORE_NONE;
         mem_read_en   <= 1'b0;
         mem_write_en  <= 1'b0;
         mem_address   <= '0;
         mem_wdata     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_tag         <= w_tag_nxt;
         req_ready     <= w_req_ready_nxt;
         resp_valid    <= w_resp_valid_nxt;
         resp_data     <= w_resp_data_nxt;
         resp_rd       <= w_resp_rd_nxt;
         resp_fault    <= w_resp_fault_nxt;
         mem_storetype <= w_storetype_nxt;
         mem_read_en   <= w_read_en_nxt;
         mem_write_en  <= w_write_en_nxt;
         mem_address   <= w_address_nxt;
         mem_wdata     <= w_wdata_nxt;
      end
   end

   // Next state plus next value of every registered output.
   always_comb begin
      w_state_nxt      = r_state;
      w_tag_nxt        = r_tag;
      w_req_ready_nxt  = 1'b0;
      w_resp_valid_nxt = 1'b0;
      w_resp_data_nxt  = resp_data;
      w_resp_rd_nxt    = resp_rd;
      w_resp_fault_nxt = resp_fault;
      w_storetype_nxt  = mem_storetype;
      w_read_en_nxt    = 1'b0;
      w_write_en_nxt   = 1'b0;
      w_address_nxt    = mem_address;
      w_wdata_nxt      = mem_wdata;

      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_tag_nxt = '{is_store: req_is_store, funct3: req_funct3, rd: req_rd};
               if (w_fault) begin
                  w_state_nxt      = S_RESP;
                  w_resp_data_nxt  = '0;
                  w_resp_rd_nxt    = req_rd;
                  w_resp_fault_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_ISSUE;
                  w_address_nxt  = w_addr;
                  w_read_en_nxt  = !req_is_store;
                  w_write_en_nxt = req_is_store;
                  if (req_is_store) begin
                     w_wdata_nxt     = req_wdata;
                     w_storetype_nxt = store_code(req_funct3[1:0]);
                  end
               end
            end
         end
         S_ISSUE: begin
            if (r_tag.is_store) begin
               w_state_nxt      = S_RESP;
               w_resp_data_nxt  = '0;
               w_resp_rd_nxt    = r_tag.rd;
               w_resp_fault_nxt = 1'b0;
            end else begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_state_nxt      = S_RESP;
            w_resp_data_nxt  = w_ext;
            w_resp_rd_nxt    = r_tag.rd;
            w_resp_fault_nxt = 1'b0;
         end
         S_RESP: begin
            if (resp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_req_ready_nxt  = (w_state_nxt == S_IDLE);
      w_resp_valid_nxt = (w_state_nxt == S_RESP);
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte memory on the memory port plus
// an array-based reference of architectural memory contents.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int unsigned MB   = 10;
   localparam int unsigned XL   = 64;
   localparam int unsigned MSZ  = 1 << MB;

   logic          clock = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_is_store;
   logic [2:0]    req_funct3;
   logic [63:0]   req_base, req_offset, req_wdata;
   logic [4:0]    req_rd;
   logic          resp_valid, resp_ready;
   logic [63:0]   resp_data;
   logic [4:0]    resp_rd;
   logic          resp_fault;
   logic [3:0]    mem_storetype;
   logic          mem_read_en, mem_write_en;
   logic [63:0]   mem_address, mem_wdata, mem_rdata;

   logic [7:0]    tb_mem  [MSZ];
   logic [7:0]    ref_mem [MSZ];

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(.MEMORY_BITS(MB), .XLEN(XL)) dut (
      .clock(clock), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_fault(resp_fault),
      .mem_storetype(mem_storetype), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Data memory: byte-addressed, registered read data, zero when not reading.
   always @(posedge clock) begin
      int n;
      int a;
      a = int'(mem_address[MB-1:0]);
      if (mem_write_en) begin
         n = (mem_storetype == STORE_BYTE) ? 1 : (mem_storetype == STORE_HALFWORD) ? 2 :
             (mem_storetype == STORE_WORD) ? 4 : (mem_storetype == STORE_DOUBLEWORD) ? 8 : 0;
         for (int i = 0; i < n; i++)
            if (a + i < MSZ) tb_mem[a + i] <= mem_wdata[8*i +: 8];
      end
      if (mem_read_en) begin
         for (int i = 0; i < 8; i++)
            mem_rdata[8*i +: 8] <= (a + i < MSZ) ? tb_mem[a + i] : 8'h00;
      end else begin
         mem_rdata <= '0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Architectural reference: fault rules, byte-wise store, extended load.
   task automatic model(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output bit fault, output logic [63:0] data);
      int size;
      int lo;
      logic [63:0] v;
      size  = 1 << f3[1:0];
      lo    = int'(addr % 64'(MSZ));
      fault = (addr >= 64'(MSZ)) || (lo + size > MSZ) || (!st && f3 == 3'd7) || (st && f3[2]);
      data  = 64'd0;
      if (!fault) begin
         if (st) begin
            for (int i = 0; i < size; i++) ref_mem[lo + i] = wdata[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = v | (64'(ref_mem[lo + i]) << (8 * i));
            if (f3 < 3'd4 && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
            data = v;
         end
      end
   endtask

   task automatic do_req(input bit st, input logic [2:0] f3, input logic [63:0] base,
                         input logic [63:0] off, input logic [63:0] wdata, input logic [4:0] rd,
                         input int hold, input bit keep_valid, output logic [63:0] got);
      bit          efault, saw_rd, both;
      logic [63:0] edata, held;
      int          lat, elat;
      model(st, f3, base + off, wdata, efault, edata);
      elat = efault ? 1 : (st ? 2 : 3);
      chk("req_ready_before", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_base = base; req_offset = off; req_wdata = wdata; req_rd = rd;
      step();
      if (!keep_valid) req_valid = 1'b0;
      lat = 1; saw_rd = 1'b0; both = 1'b0;
      while (!resp_valid && lat < 10) begin
         if (mem_read_en) saw_rd = 1'b1;
         if (mem_read_en && mem_write_en) both = 1'b1;
         step();
         lat++;
      end
      chk("latency", 64'(lat), 64'(elat));
      chk("resp_data", resp_data, edata);
      chk("resp_rd", 64'(resp_rd), 64'(rd));
      chk("resp_fault", 64'(resp_fault), 64'(efault));
      chk("read_en_seen", 64'(saw_rd), 64'(!st && !efault));
      chk("rd_wr_exclusive", 64'(both), 64'd0);
      held = resp_data;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", 64'(resp_valid), 64'd1);
         chk("hold_data", resp_data, held);
         chk("hold_req_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("post_resp_valid", 64'(resp_valid), 64'd0);
      chk("post_req_ready", 64'(req_ready), 64'd1);
      got = edata;
   endtask

   initial begin
      logic [63:0] got;
      logic [63:0] addr, base;
      bit          st;
      logic [2:0]  f3;
      int          kind, bad;
      for (int i = 0; i < MSZ; i++) begin
         tb_mem[i]  = 8'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      rst = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
      req_base = '0; req_offset = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_ctrl", {mem_storetype, mem_read_en, mem_write_en}, 64'd0);
      chk("rst_addr", mem_address, 64'd0);
      @(negedge clock);
      rst = 1'b1;
      step();

      // SD then LD of the same doubleword
      do_req(1'b1, 3'd3, 64'h10, 64'h0, 64'h8877665544332211, 5'd3, 0, 1'b0, got);
      do_req(1'b0, 3'd3, 64'h8, 64'h8, 64'h0, 5'd4, 0, 1'b0, got);
      chk("ld_value", resp_data, 64'h8877665544332211);

      // SB then signed and unsigned byte loads
      do_req(1'b1, 3'd0, 64'h20, 64'h0, 64'h12345678_9ABCDEF0, 5'd5, 0, 1'b0, got);
      do_req(1'b0, 3'd0, 64'h20, 64'h0, 64'h0, 5'd6, 0, 1'b0, got);
      chk("lb_value", got, 64'hFFFFFFFFFFFFFFF0);
      do_req(1'b0, 3'd4, 64'h20, 64'h0, 64'h0, 5'd7, 0, 1'b0, got);
      chk("lbu_value", got, 64'h00000000000000F0);

      // LW straddling the top of memory
      do_req(1'b0, 3'd2, 64'(MSZ - 2), 64'h0, 64'h0, 5'd8, 0, 1'b0, got);

      // Backpressure with req_valid held high, then immediate re-accept
      do_req(1'b0, 3'd3, 64'h100, 64'h0, 64'h0, 5'd9, 5, 1'b1, got);
      do_req(1'b0, 3'd3, 64'h100, 64'h0, 64'h0, 5'd9, 0, 1'b0, got);

      // Reset during the ISSUE cycle of a store
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
      req_base = 64'h40; req_offset = 64'h0; req_wdata = 64'hDEADBEEF; req_rd = 5'd10;
      step();
      req_valid = 1'b0;
      chk("issue_write_en", 64'(mem_write_en), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_write_en_drop", 64'(mem_write_en), 64'd0);
      step();
      rst = 1'b1;
      step();
      chk("after_rst_req_ready", 64'(req_ready), 64'd1);
      chk("after_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mem_unchanged", {tb_mem[16'h43], tb_mem[16'h42], tb_mem[16'h41], tb_mem[16'h40]},
          {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]});

      // Misaligned LH
      do_req(1'b1, 3'd0, 64'h31, 64'h0, 64'h34, 5'd11, 0, 1'b0, got);
      do_req(1'b1, 3'd0, 64'h32, 64'h0, 64'h92, 5'd12, 0, 1'b0, got);
      do_req(1'b0, 3'd1, 64'h30, 64'h1, 64'h0, 5'd13, 0, 1'b0, got);
      chk("lh_misaligned", got, 64'hFFFFFFFFFFFF9234);

      // Randomized mix including out-of-range and illegal funct3
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         st   = 1'($urandom_range(0, 1));
         f3   = st ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
         if (kind == 0)      addr = (64'h1 << $urandom_range(MB, 63)) | 64'($urandom_range(0, 63));
         else if (kind == 1) addr = 64'(MSZ - $urandom_range(1, 8));
         else                addr = 64'($urandom_range(0, 255));
         base = {32'($urandom), 32'($urandom)};
         do_req(st, f3, base, addr - base, {32'($urandom), 32'($urandom)},
                5'($urandom), $urandom_range(0, 2), 1'b0, got);
      end

      bad = 0;
      for (int i = 0; i < MSZ; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
      chk("memory_image", 64'(bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
